prbs31_checker: RTL
===================

Name: prbs31_checker

Overview:
Serial PRBS31 receiver and checker, the far end of the on-chip PRBS31 generator (polynomial x^31 + x^28 + 1).
- Self-synchronises to an incoming bit stream and declares lock.
- Once locked, compares each received bit against a locally generated sequence and counts bit errors and checked bits.
- Sits between the pad-side serial input and the status outputs.

Parameters:
LOCK_COUNT, 64, consecutive matching bits required in HUNT before declaring lock (range 1..255)
WIN_LEN, 256, LOCKED-state monitoring window length, in valid bits
LOS_THRESH, 16, errors within one window that force loss of lock (must be ≤ WIN_LEN)
ERR_W, 16, width of the error counter
BIT_W, 32, width of the checked-bit counter

Ports:
clk  in  1  clock
rst_n  in  1  reset, asynchronous, active-high
rx_valid  in  1  rx_bit qualifier; state advances only when high
rx_bit  in  1  received serial bit
clr  in  1  synchronous clear of err_count and bit_count
locked  out  1  high while FSM is in LOCKED
err_pulse  out  1  one-cycle pulse per detected error while LOCKED
err_count  out  ERR_W  saturating error count
bit_count  out  BIT_W  saturating count of bits checked while LOCKED

Behaviour:
- Reset: rst_n is asynchronous, active-high; clock is clk. While rst_n is high:
  - shift register s[30:0] = 0, fill counter = 0, match counter = 0, window counters = 0;
  - FSM = HUNT;
  - locked = 0, err_pulse = 0, err_count = 0, bit_count = 0.
  - Reset asserted mid-operation returns all of the above immediately, with no partial state kept.
- Prediction: exp = s[27] ^ s[30]. mism = rx_bit ^ exp. Shift on every rx_valid cycle: s <= {s[29:0], din}.
- HUNT state (self-synchronous):
  - din = rx_bit.
  - Fill counter increments on each valid bit up to 31. No comparison is made until it reaches 31.
  - Once filled:
    - match and s ≠ 0: match counter increments;
    - mismatch, or s == 0: match counter clears. This all-zero guard means a stuck-low line never locks.
  - When the match counter reaches LOCK_COUNT on a valid cycle, FSM moves to LOCKED and locked = 1 on the next cycle.
- LOCKED state (free-running):
  - din = exp. The local generator ignores rx_bit, so a single line error counts exactly once and does not propagate.
  - Per valid bit: bit_count += 1 (saturating at all-ones); window counter += 1.
  - On mism: err_pulse = 1 in the following cycle; err_count += 1 (saturating at all-ones); window error counter += 1.
  - When the window error counter reaches LOS_THRESH:
    - FSM moves to HUNT on the next cycle;
    - fill counter and match counter clear;
    - s is kept; err_count and bit_count are held.
  - When the window counter reaches WIN_LEN without loss of lock, both window counters clear.
- rx_valid = 0: no state changes and err_pulse = 0. Gaps of any length are transparent.
- clr: synchronous. err_count and bit_count become 0 on the next cycle.
  - clr wins over a simultaneous increment.
  - clr does not affect the FSM, s, or window counters.
- Latency: all outputs are registered. err_pulse appears 1 cycle after the valid sample carrying the error.
- Counts are not incremented in HUNT. err_pulse is never asserted in HUNT.

Decomposition:
- Shared package prbs_pkg holds:
  - PRBS_LEN = 31;
  - TAP_A = 30, TAP_B = 27;
  - seed constant PRBS_SEED = 31'd1;
  - FSM state encoding HUNT = 1'b0, LOCKED = 1'b1.
  The generator uses the same package.
- One natural sub-module: prbs31_core, holding the 31-bit shift register and the exp output, with a shift-enable and a din input. The checker instantiates it and muxes din between rx_bit and exp.
- Counters and FSM stay in the top level.

Test Plan:
- Lock acquisition: drive a generator stream (seed 31'd1) with rx_valid = 1 continuously -> locked rises on the cycle after valid bit 31 + 64 = 95; err_count = 0; bit_count increments from then on.
- Single error: after lock, invert one bit -> exactly one err_pulse one cycle later; err_count = 1; locked stays 1; no further errors.
- Stuck line: rx_bit = 0 constant for 10,000 cycles -> locked remains 0; err_count = 0. Repeat with rx_bit = 1 -> locked remains 0 (the constant-ones stream mismatches).
- Loss of lock: after lock, invert 16 consecutive bits -> locked falls the cycle after the 16th error; err_count = 16; stream then resumes clean -> relock after 31 + 64 further bits.
- Gaps and clear: after lock, toggle rx_valid pseudo-randomly over 500 valid bits -> bit_count = 500 and no errors. Then pulse clr coincident with an injected error -> err_count = 0 and bit_count = 0 on the next cycle.
- Reset mid-run: assert rst_n asynchronously while LOCKED with err_count = 5 -> locked, err_count and bit_count go to 0 without waiting for a clock edge; after release, relock takes 95 valid bits.

Source files
------------

// File: rtl/prbs_pkg.sv
// Shared PRBS31 (x^31 + x^28 + 1) constants and FSM encoding, common to the
// on-chip generator and the receive-side checker.
package prbs_pkg;

  localparam int PRBS_LEN = 31;
  localparam int TAP_A    = 30;
  localparam int TAP_B    = 27;

  localparam logic [PRBS_LEN-1:0] PRBS_SEED = 31'd1;

  typedef enum logic {
    HUNT   = 1'b0,
    LOCKED = 1'b1
  } prbs_state_t;

  function automatic logic prbs_tap(input logic [PRBS_LEN-1:0] s);
    return s[TAP_A] ^ s[TAP_B];
  endfunction

endpackage

// File: rtl/prbs31_core.sv
// 31-bit PRBS shift register with the next-bit prediction; the caller picks
// whether the register is fed from the line or from its own prediction.
module prbs31_core
  import prbs_pkg::*;
(
  input  logic                clk,
  input  logic                rst_n,
  input  logic                i_shift,
  input  logic                i_din,
  output logic                o_exp,
  output logic [PRBS_LEN-1:0] o_state
);

  logic [PRBS_LEN-1:0] r_s;

  always_ff @(posedge clk or posedge rst_n) begin
    if (rst_n) begin
      r_s <= '0;
    end else if (i_shift) begin
      r_s <= {r_s[PRBS_LEN-2:0], i_din};
    end
  end

  assign o_exp   = prbs_tap(r_s);
  assign o_state = r_s;

endmodule

// File: rtl/prbs31_checker.sv
// Serial PRBS31 checker: self-synchronises in HUNT, then free-runs in LOCKED
// counting bit errors and checked bits, dropping lock on a bad window.
//
//   state  | meaning
//   HUNT   | register fed from the line; counting consecutive matches
//   LOCKED | register fed from itself; counting errors and checked bits
module prbs31_checker
  import prbs_pkg::*;
#(
  parameter int LOCK_COUNT = 64,
  parameter int WIN_LEN    = 256,
  parameter int LOS_THRESH = 16,
  parameter int ERR_W      = 16,
  parameter int BIT_W      = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             i_rx_valid,
  input  logic             i_rx_bit,
  input  logic             i_clr,
  output logic             o_locked,
  output logic             o_err_pulse,
  output logic [ERR_W-1:0] o_err_count,
  output logic [BIT_W-1:0] o_bit_count
);

  localparam int FILL_W  = 5;
  localparam int MATCH_W = 8;
  localparam int WIN_W   = $clog2(WIN_LEN + 1);

  prbs_state_t         r_state, w_state_nxt;
  logic [FILL_W-1:0]   r_fill;
  logic [MATCH_W-1:0]  r_match;
  logic [WIN_W-1:0]    r_win_cnt, r_win_err;
  logic [ERR_W-1:0]    r_err_count;
  logic [BIT_W-1:0]    r_bit_count;
  logic                r_err_pulse;

  logic                w_exp, w_din, w_mism, w_s_zero, w_filled;
  logic                w_in_lock, w_hunt_hit, w_err, w_los, w_win_end;
  logic [PRBS_LEN-1:0] w_s;

  prbs31_core u_core (
    .clk     (clk),
    .rst_n   (rst_n),
    .i_shift (i_rx_valid),
    .i_din   (w_din),
    .o_exp   (w_exp),
    .o_state (w_s)
  );

  // In LOCKED the register regenerates itself so line errors never propagate.
  assign w_in_lock  = (r_state == LOCKED);
  assign w_din      = w_in_lock ? w_exp : i_rx_bit;
  assign w_mism     = i_rx_bit ^ w_exp;
  assign w_s_zero   = (w_s == '0);
  assign w_filled   = (r_fill == FILL_W'(PRBS_LEN));
  assign w_hunt_hit = i_rx_valid && !w_in_lock && w_filled && !w_mism && !w_s_zero
                      && (r_match == MATCH_W'(LOCK_COUNT - 1));
  assign w_err      = i_rx_valid && w_in_lock && w_mism;
  assign w_los      = w_err && (r_win_err == WIN_W'(LOS_THRESH - 1));
  assign w_win_end  = i_rx_valid && w_in_lock && (r_win_cnt == WIN_W'(WIN_LEN - 1));

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      HUNT:    if (w_hunt_hit) w_state_nxt = LOCKED;
      LOCKED:  if (w_los)      w_state_nxt = HUNT;
      default: w_state_nxt = HUNT;
    endcase
  end

  always_ff @(posedge clk or posedge rst_n) begin
    if (rst_n) begin
      r_state <= HUNT;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_ff @(posedge clk or posedge rst_n) begin
    if (rst_n) begin
      r_fill  <= '0;
      r_match <= '0;
    end else if (i_rx_valid) begin
      if (w_in_lock || w_hunt_hit) begin
        r_fill  <= '0;
        r_match <= '0;
      end else if (!w_filled) begin
        r_fill <= r_fill + 1'b1;
      end else if (!w_mism && !w_s_zero) begin
        r_match <= r_match + 1'b1;
      end else begin
        r_match <= '0;
      end
    end
  end

  always_ff @(posedge clk or posedge rst_n) begin
    if (rst_n) begin
      r_win_cnt <= '0;
      r_win_err <= '0;
    end else if (i_rx_valid && w_in_lock) begin
      if (w_los || w_win_end) begin
        r_win_cnt <= '0;
        r_win_err <= '0;
      end else begin
        r_win_cnt <= r_win_cnt + 1'b1;
        r_win_err <= r_win_err + WIN_W'(w_mism);
      end
    end
  end

  always_ff @(posedge clk or posedge rst_n) begin
    if (rst_n) begin
      r_err_count <= '0;
      r_bit_count <= '0;
      r_err_pulse <= 1'b0;
    end else begin
      r_err_pulse <= w_err;
      if (i_clr) begin
        r_err_count <= '0;
        r_bit_count <= '0;
      end else if (i_rx_valid && w_in_lock) begin
        if (r_bit_count != '1) r_bit_count <= r_bit_count + 1'b1;
        if (w_mism && (r_err_count != '1)) r_err_count <= r_err_count + 1'b1;
      end
    end
  end

  assign o_locked    = w_in_lock;
  assign o_err_pulse = r_err_pulse;
  assign o_err_count = r_err_count;
  assign o_bit_count = r_bit_count;

endmodule
